// File: rtl/arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : arb_pkg
//  Description : Shared types, constants and the round-robin search helper
//                for the four-way arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package arb_pkg;

    localparam int NREQ = 4;

    typedef enum logic {IDLE, GRANT} arb_state_t;

    typedef struct packed {
        logic       found;
        logic [1:0] idx;
    } pick_t;

    // Walks ptr, ptr+1, ... mod 4; descending order lets the nearest hit win.
    function automatic pick_t rr_pick(input logic [NREQ-1:0] req, input logic [1:0] ptr);
        pick_t      r;
        logic [1:0] k;
        r = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            k = ptr + 2'(i);
            if (req[k]) begin
                r.found = 1'b1;
                r.idx   = k;
            end
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/two_or_three.sv
`default_nettype none
// ============================================================================
//  Module      : two_or_three
//  Description : Combinational detector, high when exactly two or three of
//                the four inputs are set.
//  Revision    : 1.0 - initial release
// ============================================================================
module two_or_three
    import arb_pkg::*;
(
    input  logic [NREQ-1:0] i_v,
    output logic            o_hit
);

    logic w_ge2;

    assign w_ge2 = (i_v[0] & i_v[1]) | (i_v[0] & i_v[2]) | (i_v[0] & i_v[3]) |
                   (i_v[1] & i_v[2]) | (i_v[1] & i_v[3]) | (i_v[2] & i_v[3]);
    assign o_hit = w_ge2 & ~(&i_v);

endmodule
`default_nettype wire

// File: rtl/rr_arbiter4.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter4
//  Description : Four-way round-robin arbiter with registered one-hot grant,
//                hold limit and registered contention flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter4
    import arb_pkg::*;
#(
    parameter int HOLD_MAX = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    input  logic            done,
    output logic [NREQ-1:0] gnt,
    output logic            busy,
    output logic [1:0]      owner,
    output logic            contention
);

    arb_state_t      r_state;
    logic [NREQ-1:0] r_gnt;
    logic [1:0]      r_owner;
    logic [1:0]      r_ptr;
    logic [7:0]      r_cnt;
    logic            r_contention;

    arb_state_t      w_state_nxt;
    logic [NREQ-1:0] w_gnt_nxt;
    logic [1:0]      w_owner_nxt;
    logic [1:0]      w_ptr_nxt;
    logic [7:0]      w_cnt_nxt;
    logic            w_release;
    logic            w_two_three;
    pick_t           w_pick;

    assign w_pick    = rr_pick(req, r_ptr);
    assign w_release = done | ~req[r_owner] | (r_cnt == 8'(HOLD_MAX - 1));

    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_owner_nxt = r_owner;
        w_ptr_nxt   = r_ptr;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            IDLE: begin
                if (w_pick.found) begin
                    w_state_nxt = GRANT;
                    w_gnt_nxt   = 4'b0001 << w_pick.idx;
                    w_owner_nxt = w_pick.idx;
                    w_cnt_nxt   = 8'd0;
                end
            end
            GRANT: begin
                // Release always passes through IDLE, giving one dead cycle.
                if (w_release) begin
                    w_state_nxt = IDLE;
                    w_gnt_nxt   = '0;
                    w_owner_nxt = 2'd0;
                    w_ptr_nxt   = r_owner + 2'd1;
                end else begin
                    w_cnt_nxt   = r_cnt + 8'd1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_gnt   <= '0;
            r_owner <= 2'd0;
            r_ptr   <= 2'd0;
            r_cnt   <= 8'd0;
        end else begin
            r_state <= w_state_nxt;
            r_gnt   <= w_gnt_nxt;
            r_owner <= w_owner_nxt;
            r_ptr   <= w_ptr_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    two_or_three u_two_or_three (
        .i_v   (req),
        .o_hit (w_two_three)
    );

    always_ff @(posedge clk) begin
        if (rst) r_contention <= 1'b0;
        else     r_contention <= w_two_three | (&req);
    end

    assign gnt        = r_gnt;
    assign busy       = |r_gnt;
    assign owner      = r_owner;
    assign contention = r_contention;

endmodule
`default_nettype wire

// File: tb/tb_rr_arbiter4.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rr_arbiter4
//  Description : Self-checking bench for rr_arbiter4 with directed scenarios
//                and randomized traffic against a behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rr_arbiter4;

    localparam int HOLD_MAX = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic       done;
    logic [3:0] gnt;
    logic       busy;
    logic [1:0] owner;
    logic       contention;

    int n_cmp = 0;
    int n_err = 0;

    rr_arbiter4 #(.HOLD_MAX(HOLD_MAX)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .done       (done),
        .gnt        (gnt),
        .busy       (busy),
        .owner      (owner),
        .contention (contention)
    );

    always #5 clk = ~clk;

    // Behavioural model: who holds the resource, for how long, and whose turn is next.
    int m_busy = 0, m_owner = 0, m_ptr = 0, m_held = 0, m_cont = 0;

    always @(posedge clk) begin
        int ones;
        ones = 0;
        for (int b = 0; b < 4; b++) ones += int'(req[b]);
        if (rst) begin
            m_busy = 0; m_owner = 0; m_ptr = 0; m_held = 0; m_cont = 0;
        end else begin
            m_cont = (ones >= 2) ? 1 : 0;
            if (m_busy == 0) begin
                for (int i = 3; i >= 0; i--)
                    if (req[(m_ptr + i) % 4]) begin
                        m_owner = (m_ptr + i) % 4;
                        m_busy  = 1;
                        m_held  = 1;
                    end
            end else if (done || !req[m_owner] || m_held == HOLD_MAX) begin
                m_ptr   = (m_owner + 1) % 4;
                m_busy  = 0;
                m_owner = 0;
            end else begin
                m_held++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; req = 4'b0000; done = 1'b0;
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req = 4'b1111; done = 1'b0;
        tick(); tick();
        n_cmp++;
        if (gnt !== 4'b0000 || busy !== 1'b0 || owner !== 2'd0 || contention !== 1'b0) begin
            n_err++;
            $display("FAIL reset: gnt=%b busy=%b owner=%0d cont=%b, want 0000/0/0/0", gnt, busy, owner, contention);
        end
        rst = 1'b0;
        tick();
        n_cmp++;
        if (gnt !== 4'b0001 || busy !== 1'b1 || contention !== 1'b1) begin
            n_err++;
            $display("FAIL reset_first_grant: gnt=%b busy=%b cont=%b, want 0001/1/1", gnt, busy, contention);
        end
    endtask

    task automatic test_single_done();
        do_reset();
        req = 4'b0100;
        tick();
        n_cmp++;
        if (gnt !== 4'b0100 || owner !== 2'd2) begin
            n_err++;
            $display("FAIL single_grant: gnt=%b owner=%0d, want 0100/2", gnt, owner);
        end
        tick(); tick();
        done = 1'b1;
        tick();
        done = 1'b0;
        n_cmp++;
        if (gnt !== 4'b0000 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL single_done_release: gnt=%b busy=%b, want 0000/0", gnt, busy);
        end
        tick();
        n_cmp++;
        if (gnt !== 4'b0100 || owner !== 2'd2) begin
            n_err++;
            $display("FAIL single_regrant: gnt=%b owner=%0d, want 0100/2", gnt, owner);
        end
    endtask

    task automatic test_all_hold();
        logic [3:0] want;
        do_reset();
        req = 4'b1111;
        tick();
        for (int g = 0; g < 5; g++) begin
            want = 4'b0001 << (g % 4);
            for (int c = 0; c < HOLD_MAX; c++) begin
                n_cmp++;
                if (gnt !== want) begin
                    n_err++;
                    $display("FAIL all_hold g%0d c%0d: gnt=%b want %b", g, c, gnt, want);
                end
                tick();
            end
            n_cmp++;
            if (gnt !== 4'b0000) begin
                n_err++;
                $display("FAIL all_hold_gap g%0d: gnt=%b want 0000", g, gnt);
            end
            tick();
        end
    endtask

    task automatic test_owner_drop();
        do_reset();
        req = 4'b0010;
        tick();
        req = 4'b1010;
        tick();
        n_cmp++;
        if (gnt !== 4'b0010 || owner !== 2'd1) begin
            n_err++;
            $display("FAIL drop_hold: gnt=%b owner=%0d, want 0010/1", gnt, owner);
        end
        req = 4'b1000;
        tick();
        n_cmp++;
        if (gnt !== 4'b0000 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL drop_release: gnt=%b busy=%b, want 0000/0", gnt, busy);
        end
        tick();
        n_cmp++;
        if (gnt !== 4'b1000 || owner !== 2'd3) begin
            n_err++;
            $display("FAIL drop_next: gnt=%b owner=%0d, want 1000/3", gnt, owner);
        end
    endtask

    task automatic test_done_timeout();
        do_reset();
        req = 4'b1111;
        tick();
        for (int c = 1; c < HOLD_MAX; c++) tick();
        n_cmp++;
        if (gnt !== 4'b0001) begin
            n_err++;
            $display("FAIL dt_last_cycle: gnt=%b want 0001", gnt);
        end
        done = 1'b1;
        tick();
        done = 1'b0;
        n_cmp++;
        if (gnt !== 4'b0000) begin
            n_err++;
            $display("FAIL dt_release: gnt=%b want 0000", gnt);
        end
        tick();
        n_cmp++;
        if (gnt !== 4'b0010 || owner !== 2'd1) begin
            n_err++;
            $display("FAIL dt_next_owner: gnt=%b owner=%0d, want 0010/1", gnt, owner);
        end
    endtask

    task automatic test_contention_sweep();
        int ones;
        logic want;
        do_reset();
        for (int v = 0; v < 16; v++) begin
            req = 4'(v);
            ones = 0;
            for (int b = 0; b < 4; b++) ones += (v >> b) & 1;
            want = (ones >= 2);
            tick();
            n_cmp++;
            if (contention !== want) begin
                n_err++;
                $display("FAIL contention req=%b: got %b want %b", req, contention, want);
            end
        end
    endtask

    task automatic test_reset_midgrant();
        do_reset();
        req = 4'b0001; tick();
        req = 4'b0000; tick();
        req = 4'b0010; tick();
        req = 4'b1111; tick();
        rst = 1'b1;
        tick();
        n_cmp++;
        if (gnt !== 4'b0000 || busy !== 1'b0 || owner !== 2'd0) begin
            n_err++;
            $display("FAIL midreset_drop: gnt=%b busy=%b owner=%0d, want 0000/0/0", gnt, busy, owner);
        end
        rst = 1'b0;
        tick();
        n_cmp++;
        if (gnt !== 4'b0001) begin
            n_err++;
            $display("FAIL midreset_ptr: gnt=%b want 0001", gnt);
        end
    endtask

    task automatic test_random();
        logic [3:0] want_gnt;
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
            done = ($urandom_range(0, 9) == 0);
            rst  = ($urandom_range(0, 199) == 0);
            tick();
            want_gnt = (m_busy != 0) ? (4'b0001 << m_owner) : 4'b0000;
            n_cmp++;
            if (gnt !== want_gnt || busy !== (m_busy != 0) || owner !== 2'(m_owner) ||
                contention !== (m_cont != 0)) begin
                n_err++;
                $display("FAIL random n=%0d: gnt=%b busy=%b owner=%0d cont=%b, want %b/%0d/%0d/%0d",
                         n, gnt, busy, owner, contention, want_gnt, m_busy, m_owner, m_cont);
            end
        end
        rst = 1'b0; done = 1'b0;
    endtask

    initial begin
        rst = 1'b1; req = 4'b0000; done = 1'b0;
        @(negedge clk);
        test_reset();
        test_single_done();
        test_all_hold();
        test_owner_drop();
        test_done_timeout();
        test_contention_sweep();
        test_reset_midgrant();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
